// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
//   Shared definitions for the 4-tap FIR filter and its coefficient loader.
//   - DEF_NTAPS / DEF_CW : default tap count and coefficient width
//   - YW                 : filter output width, 2*CW + clog2(NTAPS)
//   - coeff_state_t      : loader FSM states
//   - idx_w()            : width of a tap index (never narrower than 1 bit)
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int unsigned DEF_NTAPS = 4;
    localparam int unsigned DEF_CW    = 4;
    localparam int unsigned YW        = 2 * DEF_CW + $clog2(DEF_NTAPS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } coeff_state_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/coeff_reg_bank.sv
// -----------------------------------------------------------------------------
// coeff_reg_bank
//   NTAPS x CW coefficient register array, asynchronously cleared to zero.
//   Two ways to write it:
//     - single entry : i_wr_en, i_wr_idx, i_wr_data (shadow bank usage)
//     - whole bank   : i_ld_en, i_ld_data         (active bank usage)
//   A whole-bank load takes priority over a single-entry write.
// Ports:
//   i_clk      in   clock, rising edge
//   i_rst_n    in   asynchronous active-low reset
//   i_wr_en    in   write one entry
//   i_wr_idx   in   entry index for i_wr_en
//   i_wr_data  in   entry value for i_wr_en
//   i_ld_en    in   load all entries in parallel
//   i_ld_data  in   values for i_ld_en
//   o_q        out  current register contents
// -----------------------------------------------------------------------------
module coeff_reg_bank
    import fir_pkg::*;
#(
    parameter int unsigned NTAPS = DEF_NTAPS,
    parameter int unsigned CW    = DEF_CW,
    parameter int unsigned IW    = idx_w(NTAPS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_wr_en,
    input  logic [IW-1:0]             i_wr_idx,
    input  logic [CW-1:0]             i_wr_data,
    input  logic                      i_ld_en,
    input  logic [NTAPS-1:0][CW-1:0]  i_ld_data,
    output logic [NTAPS-1:0][CW-1:0]  o_q
);

    logic [NTAPS-1:0][CW-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_ld_en) begin
            r_q <= i_ld_data;
        end else if (i_wr_en) begin
            for (int unsigned k = 0; k < NTAPS; k++) begin
                if (i_wr_idx == IW'(k)) begin
                    r_q[k] <= i_wr_data;
                end
            end
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// fir_coeff_loader
//   Collects a frame of NTAPS coefficients over a valid/ready stream into a
//   shadow bank, then copies the whole frame into the active bank in a single
//   COMMIT cycle so the downstream filter never sees a partial update.
// Ports:
//   CLK          in   clock, rising edge
//   RST_N        in   asynchronous active-low reset
//   load_start   in   opens or restarts a frame (one-cycle pulse)
//   coeff_valid  in   coefficient beat present
//   coeff_data   in   coefficient value; beat k lands in h[k]
//   coeff_ready  out  beat accepted this cycle (state decode only)
//   h            out  active coefficient bank, registered
//   busy         out  high in LOAD or COMMIT
//   done         out  one-cycle pulse in the cycle the new h first appears
//   load_count   out  committed frames, wraps 255 -> 0
// -----------------------------------------------------------------------------
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int unsigned NTAPS = DEF_NTAPS,
    parameter int unsigned CW    = DEF_CW
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      load_start,
    input  logic                      coeff_valid,
    input  logic [CW-1:0]             coeff_data,
    output logic                      coeff_ready,
    output logic [NTAPS-1:0][CW-1:0]  h,
    output logic                      busy,
    output logic                      done,
    output logic [7:0]                load_count
);

    localparam int unsigned IW = idx_w(NTAPS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);

    coeff_state_t              r_state;
    coeff_state_t              w_state_nxt;
    logic [IW-1:0]             r_idx;
    logic [IW-1:0]             w_idx_nxt;
    logic                      w_ready;
    logic                      w_busy;
    logic                      w_shadow_we;
    logic                      w_commit;
    logic                      r_done;
    logic [7:0]                r_load_count;
    logic [NTAPS-1:0][CW-1:0]  w_shadow;
    logic [NTAPS-1:0][CW-1:0]  w_active;

    // State and index registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state, index and decoded outputs. coeff_ready/busy depend on
    // r_state alone; the inputs only steer next state and the shadow write.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        w_shadow_we = 1'b0;
        w_commit    = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (load_start) begin
                    w_state_nxt = LOAD;
                    w_idx_nxt   = '0;
                end
            end

            LOAD: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                // Restart beats a simultaneous transfer: the beat is
                // handshaken but never written.
                if (load_start) begin
                    w_idx_nxt = '0;
                end else if (coeff_valid) begin
                    w_shadow_we = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = COMMIT;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end

            COMMIT: begin
                w_busy      = 1'b1;
                w_commit    = 1'b1;
                w_idx_nxt   = '0;
                w_state_nxt = load_start ? LOAD : IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // done and load_count are registered off the COMMIT cycle, so they move
    // on the same edge as the active bank.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_done       <= 1'b0;
            r_load_count <= '0;
        end else begin
            r_done <= w_commit;
            if (w_commit) begin
                r_load_count <= r_load_count + 8'd1;
            end
        end
    end

    coeff_reg_bank #(
        .NTAPS (NTAPS),
        .CW    (CW),
        .IW    (IW)
    ) u_shadow (
        .i_clk     (CLK),
        .i_rst_n   (RST_N),
        .i_wr_en   (w_shadow_we),
        .i_wr_idx  (r_idx),
        .i_wr_data (coeff_data),
        .i_ld_en   (1'b0),
        .i_ld_data ('0),
        .o_q       (w_shadow)
    );

    coeff_reg_bank #(
        .NTAPS (NTAPS),
        .CW    (CW),
        .IW    (IW)
    ) u_active (
        .i_clk     (CLK),
        .i_rst_n   (RST_N),
        .i_wr_en   (1'b0),
        .i_wr_idx  ('0),
        .i_wr_data ('0),
        .i_ld_en   (w_commit),
        .i_ld_data (w_shadow),
        .o_q       (w_active)
    );

    assign coeff_ready = w_ready;
    assign busy        = w_busy;
    assign done        = r_done;
    assign load_count  = r_load_count;
    assign h           = w_active;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// tb_fir_coeff_loader
//   Directed and randomized frames for fir_coeff_loader. The reference model
//   is transaction level: a committed frame's beats become h verbatim and the
//   commit counter advances modulo 256.
// -----------------------------------------------------------------------------
module tb_fir_coeff_loader;

    localparam int unsigned NT = 4;
    localparam int unsigned W  = 4;

    logic                  CLK;
    logic                  RST_N;
    logic                  load_start;
    logic                  coeff_valid;
    logic [W-1:0]          coeff_data;
    logic                  coeff_ready;
    logic [NT-1:0][W-1:0]  h;
    logic                  busy;
    logic                  done;
    logic [7:0]            load_count;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int exp_h[NT];
    int exp_cnt;

    fir_coeff_loader #(
        .NTAPS (NT),
        .CW    (W)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .load_start  (load_start),
        .coeff_valid (coeff_valid),
        .coeff_data  (coeff_data),
        .coeff_ready (coeff_ready),
        .h           (h),
        .busy        (busy),
        .done        (done),
        .load_count  (load_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] pack_h(input int a[NT]);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < int'(NT); k++) begin
            r[4*k +: 4] = a[k][3:0];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < int'(NT); k++) exp_h[k] = 0;
        exp_cnt = 0;
    endtask

    // Idle cycles, optionally offering beats that must not be taken.
    task automatic idle_cycles(input int n, input bit offer);
        for (int i = 0; i < n; i++) begin
            coeff_valid = offer;
            coeff_data  = W'($urandom_range(0, 15));
            tick();
            chk("idle_ready", 32'(coeff_ready), 32'd0);
            chk("idle_busy",  32'(busy),        32'd0);
            chk("idle_done",  32'(done),        32'd0);
            chk("idle_h",     32'(h),           pack_h(exp_h));
        end
        coeff_valid = 1'b0;
    endtask

    // One frame: optional load_start, beats b[k] each preceded by g[k] stall
    // cycles, then the commit. With chain set, load_start is raised during
    // the commit cycle so the loader lands in LOAD straight after done.
    task automatic send_frame(input int b[NT], input int g[NT],
                              input bit skip_start, input bit chain);
        if (!skip_start) begin
            load_start = 1'b1;
            tick();
            load_start = 1'b0;
        end
        chk("ready_in_load", 32'(coeff_ready), 32'd1);
        chk("busy_in_load",  32'(busy),        32'd1);
        for (int k = 0; k < int'(NT); k++) begin
            for (int j = 0; j < g[k]; j++) begin
                coeff_valid = 1'b0;
                coeff_data  = W'($urandom_range(0, 15));
                tick();
                chk("stall_h_hold", 32'(h),           pack_h(exp_h));
                chk("stall_ready",  32'(coeff_ready), 32'd1);
            end
            coeff_valid = 1'b1;
            coeff_data  = W'(b[k]);
            tick();
            coeff_valid = 1'b0;
            chk("beat_done_low", 32'(done),        32'd0);
            chk("beat_h_hold",   32'(h),           pack_h(exp_h));
            chk("beat_ready",    32'(coeff_ready), (k == int'(NT) - 1) ? 32'd0 : 32'd1);
        end
        chk("commit_busy",  32'(busy),       32'd1);
        chk("commit_count", 32'(load_count), 32'(exp_cnt));
        if (chain) load_start = 1'b1;
        tick();
        load_start = 1'b0;
        exp_h   = b;
        exp_cnt = (exp_cnt + 1) % 256;
        chk("done_pulse",  32'(done),        32'd1);
        chk("h_committed", 32'(h),           pack_h(exp_h));
        chk("count_after", 32'(load_count),  32'(exp_cnt));
        chk("busy_after",  32'(busy),        chain ? 32'd1 : 32'd0);
        chk("ready_after", 32'(coeff_ready), chain ? 32'd1 : 32'd0);
    endtask

    initial begin
        int bb[NT];
        int gg[NT];
        int zg[NT];

        zg = '{0, 0, 0, 0};
        RST_N       = 1'b0;
        load_start  = 1'b0;
        coeff_valid = 1'b0;
        coeff_data  = '0;
        model_reset();

        // Reset state
        repeat (3) tick();
        chk("rst_h",     32'(h),           32'd0);
        chk("rst_ready", 32'(coeff_ready), 32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_done",  32'(done),        32'd0);
        chk("rst_count", 32'(load_count),  32'd0);
        RST_N = 1'b1;
        idle_cycles(3, 1'b1);

        // Back-to-back frame 3,5,7,9
        bb = '{3, 5, 7, 9};
        send_frame(bb, zg, 1'b0, 1'b0);
        chk("b2b_h0", 32'(h[0]), 32'd3);
        chk("b2b_h3", 32'(h[3]), 32'd9);
        idle_cycles(2, 1'b0);

        // Stalled frame 1,2,15,4 with 2-3 idle cycles between beats
        bb = '{1, 2, 15, 4};
        gg = '{0, 2, 3, 2};
        send_frame(bb, gg, 1'b0, 1'b0);
        idle_cycles(2, 1'b1);

        // Restart: 8,8 then load_start together with beat 6, then 1,1,1,1
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            coeff_valid = 1'b1;
            coeff_data  = 4'd8;
            tick();
        end
        load_start  = 1'b1;
        coeff_valid = 1'b1;
        coeff_data  = 4'd6;
        tick();
        load_start  = 1'b0;
        coeff_valid = 1'b0;
        chk("restart_ready", 32'(coeff_ready), 32'd1);
        chk("restart_h",     32'(h),           pack_h(exp_h));
        bb = '{1, 1, 1, 1};
        send_frame(bb, zg, 1'b1, 1'b0);
        idle_cycles(1, 1'b0);

        // Reset mid-frame after 3 beats
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            coeff_valid = 1'b1;
            coeff_data  = W'($urandom_range(0, 15));
            tick();
        end
        coeff_valid = 1'b0;
        RST_N = 1'b0;
        #2;
        model_reset();
        chk("midrst_h",     32'(h),           32'd0);
        chk("midrst_busy",  32'(busy),        32'd0);
        chk("midrst_ready", 32'(coeff_ready), 32'd0);
        chk("midrst_count", 32'(load_count),  32'd0);
        tick();
        RST_N = 1'b1;
        idle_cycles(1, 1'b1);
        for (int k = 0; k < int'(NT); k++) begin
            bb[k] = int'($urandom_range(0, 15));
            gg[k] = int'($urandom_range(0, 2));
        end
        send_frame(bb, gg, 1'b0, 1'b0);
        idle_cycles(1, 1'b0);

        // Counter wrap: reset, then 256 chained random frames
        RST_N = 1'b0;
        #2;
        model_reset();
        tick();
        RST_N = 1'b1;
        for (int f = 0; f < 256; f++) begin
            for (int k = 0; k < int'(NT); k++) begin
                bb[k] = int'($urandom_range(0, 15));
                gg[k] = (f % 16 == 0) ? int'($urandom_range(0, 3)) : 0;
            end
            send_frame(bb, gg, (f != 0), (f != 255));
        end
        chk("wrap_count_zero", 32'(load_count), 32'd0);
        idle_cycles(3, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
